// File: rtl/knightrider_trail_pwm.sv
// ---------------------------------------------------------------------------
// knightrider_trail_pwm
//
// Afterglow PWM stage behind the Knight Rider scanner. Every LED that the
// scanner lights is set to full brightness. Every LED it does not light fades
// by DECAY_STEP on each scanner step, which leaves a fading trail behind the
// moving dot. New brightness levels are collected in a shadow set and only
// become active at a PWM period boundary, so a period is never cut short or
// stretched.
//
// Parameters
//   N_LEDS     number of LED channels (width of leds_in / pwm_o)
//   PWM_BITS   brightness resolution; LVL_MAX = 2**PWM_BITS-1
//   DECAY_STEP level removed from an unlit channel per step (1..LVL_MAX)
//
// Ports
//   clk      in   system clock, rising edge
//   arst     in   synchronous active-high reset, highest priority
//   en       in   block enable; when low, all state holds and outputs go low
//   step     in   one-cycle pulse, scanner advanced; qualifies leds_in
//   leds_in  in   scanner pattern, normally one-hot, sampled with step
//   pwm_o    out  registered PWM drive, one bit per LED
//   frame_o  out  registered one-cycle pulse when a new period starts with
//                 freshly loaded levels
// ---------------------------------------------------------------------------
module knightrider_trail_pwm #(
  parameter int N_LEDS     = 8,
  parameter int PWM_BITS   = 4,
  parameter int DECAY_STEP = 4
) (
  input  logic              clk,
  input  logic              arst,
  input  logic              en,
  input  logic              step,
  input  logic [N_LEDS-1:0] leds_in,
  output logic [N_LEDS-1:0] pwm_o,
  output logic              frame_o
);

  localparam int LVL_MAX = (1 << PWM_BITS) - 1;

  localparam logic [PWM_BITS-1:0] LVL_FULL = PWM_BITS'(LVL_MAX);
  // The counter runs 0..LVL_MAX-1, so one period lasts LVL_MAX cycles and a
  // level of LVL_MAX keeps the output high through the whole period.
  localparam logic [PWM_BITS-1:0] CNT_LAST = PWM_BITS'(LVL_MAX - 1);
  localparam logic [PWM_BITS-1:0] DECAY    = PWM_BITS'(DECAY_STEP);

  // Fade a level by DECAY, clamping at zero. The subtraction is done one bit
  // wider and signed so an underflow shows up as a negative result instead of
  // wrapping back to a bright level.
  function automatic logic [PWM_BITS-1:0] sat_decay(
    input logic [PWM_BITS-1:0] lvl
  );
    logic signed [PWM_BITS:0] diff;
    diff = $signed({1'b0, lvl}) - $signed({1'b0, DECAY});
    if (diff[PWM_BITS]) begin
      return '0;
    end
    return diff[PWM_BITS-1:0];
  endfunction

  // PWM compare: a level L is high while the counter is below L, giving
  // exactly L high cycles out of LVL_MAX.
  function automatic logic pwm_compare(
    input logic [PWM_BITS-1:0] cnt,
    input logic [PWM_BITS-1:0] lvl
  );
    return cnt < lvl;
  endfunction

  // ---- stage p0: period counter, shadow and active level sets ----
  logic [PWM_BITS-1:0] pwm_cnt_p0;
  logic [PWM_BITS-1:0] shadow_lvl_p0 [N_LEDS];
  logic [PWM_BITS-1:0] act_lvl_p0    [N_LEDS];

  logic                period_end_p0;
  logic                step_acc_p0;
  logic [PWM_BITS-1:0] shadow_nxt_p0 [N_LEDS];
  logic [N_LEDS-1:0]   pwm_nxt_p0;

  // ---- stage p1: registered pin drive ----
  logic [N_LEDS-1:0]   pwm_p1;
  logic                frame_p1;

  assign period_end_p0 = en && (pwm_cnt_p0 == CNT_LAST);
  assign step_acc_p0   = en && step;

  // Next shadow levels. leds_in is only looked at when a step is accepted.
  always_comb begin
    for (int i = 0; i < N_LEDS; i++) begin
      shadow_nxt_p0[i] = shadow_lvl_p0[i];
      if (step_acc_p0) begin
        shadow_nxt_p0[i] = leds_in[i] ? LVL_FULL : sat_decay(shadow_lvl_p0[i]);
      end
    end
  end

  // Output bits are built from the current counter and the levels that are
  // active right now; the register below adds the one-cycle delay.
  always_comb begin
    pwm_nxt_p0 = '0;
    for (int i = 0; i < N_LEDS; i++) begin
      pwm_nxt_p0[i] = en & pwm_compare(pwm_cnt_p0, act_lvl_p0[i]);
    end
  end

  always_ff @(posedge clk) begin
    if (arst) begin
      pwm_cnt_p0 <= '0;
      for (int i = 0; i < N_LEDS; i++) begin
        shadow_lvl_p0[i] <= '0;
        act_lvl_p0[i]    <= '0;
      end
      pwm_p1   <= '0;
      frame_p1 <= 1'b0;
    end else begin
      if (en) begin
        pwm_cnt_p0 <= period_end_p0 ? '0 : pwm_cnt_p0 + 1'b1;
      end
      for (int i = 0; i < N_LEDS; i++) begin
        shadow_lvl_p0[i] <= shadow_nxt_p0[i];
        // Loads the shadow value from before this edge, so a step landing on
        // the period end only becomes visible one period later.
        if (period_end_p0) begin
          act_lvl_p0[i] <= shadow_lvl_p0[i];
        end
      end
      // ---- stage p1 ----
      pwm_p1   <= pwm_nxt_p0;
      frame_p1 <= period_end_p0;
    end
  end

  assign pwm_o   = pwm_p1;
  assign frame_o = frame_p1;

endmodule

// File: tb/tb_knightrider_trail_pwm.sv
module tb_knightrider_trail_pwm;

  localparam int N    = 8;
  localparam int PB   = 4;
  localparam int LMAX = 15;
  localparam int DEC  = 4;

  logic         clk = 1'b0;
  logic         arst;
  logic         en;
  logic         step;
  logic [N-1:0] leds_in;
  logic [N-1:0] pwm_o;
  logic         frame_o;

  int errors = 0;
  int checks = 0;

  knightrider_trail_pwm #(
    .N_LEDS    (N),
    .PWM_BITS  (PB),
    .DECAY_STEP(DEC)
  ) dut (
    .clk    (clk),
    .arst   (arst),
    .en     (en),
    .step   (step),
    .leds_in(leds_in),
    .pwm_o  (pwm_o),
    .frame_o(frame_o)
  );

  always #5 clk = ~clk;

  // Reference model: brightness per channel as plain integers, period
  // position derived from the number of enabled cycles since reset.
  int           m_sh [N];
  int           m_ac [N];
  int           m_en_cycles;
  logic [N-1:0] m_pwm;
  logic         m_frame;

  // High-cycle counters per channel, accumulated on every sampled cycle.
  int hi [N];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_edge(input logic a, input logic e, input logic s, input logic [N-1:0] l);
    int phase;
    int new_sh [N];
    if (a) begin
      m_en_cycles = 0;
      for (int i = 0; i < N; i++) begin
        m_sh[i] = 0;
        m_ac[i] = 0;
      end
      m_pwm   = '0;
      m_frame = 1'b0;
    end else if (!e) begin
      m_pwm   = '0;
      m_frame = 1'b0;
    end else begin
      phase = m_en_cycles % LMAX;
      for (int i = 0; i < N; i++) begin
        m_pwm[i] = (phase < m_ac[i]);
        if (s) new_sh[i] = l[i] ? LMAX : ((m_sh[i] > DEC) ? m_sh[i] - DEC : 0);
        else   new_sh[i] = m_sh[i];
      end
      m_frame = (phase == LMAX - 1);
      for (int i = 0; i < N; i++) begin
        if (m_frame) m_ac[i] = m_sh[i];
        m_sh[i] = new_sh[i];
      end
      m_en_cycles++;
    end
  endtask

  task automatic clear_hi();
    for (int i = 0; i < N; i++) hi[i] = 0;
  endtask

  // One clock: drive inputs, take the edge, sample 1 time unit later and
  // compare against the model.
  task automatic cycle(input logic a, input logic e, input logic s, input logic [N-1:0] l);
    arst = a; en = e; step = s; leds_in = l;
    @(posedge clk);
    model_edge(a, e, s, l);
    #1;
    chk("pwm_model", 32'(pwm_o), 32'(m_pwm));
    chk("frame_model", 32'(frame_o), 32'(m_frame));
    for (int i = 0; i < N; i++) hi[i] += int'(pwm_o[i]);
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) cycle(1'b0, 1'b1, 1'b0, N'($urandom));
  endtask

  task automatic run_until_frame(input int budget, output int n);
    n = 0;
    do begin
      cycle(1'b0, 1'b1, 1'b0, N'($urandom));
      n++;
    end while (frame_o !== 1'b1 && n < budget);
    if (frame_o !== 1'b1) chk("frame_timeout", 32'(frame_o), 32'd1);
  endtask

  task automatic measure();
    clear_hi();
    idle(LMAX);
    chk("period_frame", 32'(frame_o), 32'd1);
  endtask

  typedef struct {
    logic         arst;
    logic         en;
    logic         step;
    logic [N-1:0] leds;
    logic [N-1:0] exp_pwm;
    logic         exp_frame;
  } vec_t;

  vec_t tbl [32];

  initial begin
    int n;
    int total;
    logic a, e, s;
    logic [N-1:0] l;

    // Reset for two cycles with random inputs, then 30 enabled idle cycles:
    // outputs stay dark and frame pulses on enabled cycles 15 and 30.
    for (int k = 0; k < 32; k++) begin
      if (k < 2) begin
        tbl[k] = '{arst: 1'b1, en: 1'($urandom), step: 1'($urandom),
                   leds: N'($urandom), exp_pwm: '0, exp_frame: 1'b0};
      end else begin
        tbl[k] = '{arst: 1'b0, en: 1'b1, step: 1'b0, leds: N'($urandom),
                   exp_pwm: '0, exp_frame: ((k - 1) % LMAX == 0)};
      end
    end

    arst = 1'b1; en = 1'b0; step = 1'b0; leds_in = '0;
    clear_hi();

    for (int k = 0; k < 32; k++) begin
      cycle(tbl[k].arst, tbl[k].en, tbl[k].step, tbl[k].leds);
      chk($sformatf("tbl_pwm[%0d]", k), 32'(pwm_o), 32'(tbl[k].exp_pwm));
      chk($sformatf("tbl_frame[%0d]", k), 32'(frame_o), 32'(tbl[k].exp_frame));
    end

    // Single step on LED 0: fully lit in the period after the next frame.
    cycle(1'b0, 1'b1, 1'b1, 8'h01);
    run_until_frame(2 * LMAX, n);
    measure();
    chk("single_ch0", 32'(hi[0]), 32'd15);
    total = 0;
    for (int i = 1; i < N; i++) total += hi[i];
    chk("single_others", 32'(total), 32'd0);

    // Trail: one step per period, levels fade by 4 behind the dot.
    for (int p = 0; p < 4; p++) begin
      l = N'(1 << p);
      cycle(1'b0, 1'b1, 1'b1, l);
      run_until_frame(2 * LMAX, n);
    end
    measure();
    chk("trail_ch0", 32'(hi[0]), 32'd3);
    chk("trail_ch1", 32'(hi[1]), 32'd7);
    chk("trail_ch2", 32'(hi[2]), 32'd11);
    chk("trail_ch3", 32'(hi[3]), 32'd15);
    cycle(1'b0, 1'b1, 1'b1, 8'h10);
    run_until_frame(2 * LMAX, n);
    measure();
    chk("sat_ch0", 32'(hi[0]), 32'd0);
    chk("sat_ch4", 32'(hi[4]), 32'd15);

    // Step landing exactly on the period end: old levels for one more period.
    idle(LMAX - 1);
    cycle(1'b0, 1'b1, 1'b1, 8'h80);
    chk("coinc_frame", 32'(frame_o), 32'd1);
    measure();
    chk("coinc_old_ch7", 32'(hi[7]), 32'd0);
    measure();
    chk("coinc_new_ch7", 32'(hi[7]), 32'd15);

    // Pause mid-period: outputs dark, steps ignored, period resumes.
    clear_hi();
    idle(5);
    for (int k = 0; k < 10; k++) begin
      cycle(1'b0, 1'b0, 1'($urandom_range(0, 1)), N'($urandom));
      chk("pause_pwm", 32'(pwm_o), 32'd0);
      chk("pause_frame", 32'(frame_o), 32'd0);
    end
    run_until_frame(2 * LMAX, n);
    chk("pause_resume_len", 32'(n), 32'd10);
    chk("pause_ch4", 32'(hi[4]), 32'd11);
    chk("pause_ch7", 32'(hi[7]), 32'd15);
    measure();
    chk("pause_after_ch4", 32'(hi[4]), 32'd11);
    chk("pause_after_ch3", 32'(hi[3]), 32'd7);

    // Reset mid-period while lit: dark until a new step meets a period end.
    idle(5);
    cycle(1'b1, 1'b1, 1'b1, 8'hFF);
    chk("arst_pwm", 32'(pwm_o), 32'd0);
    chk("arst_frame", 32'(frame_o), 32'd0);
    clear_hi();
    idle(2 * LMAX);
    total = 0;
    for (int i = 0; i < N; i++) total += hi[i];
    chk("arst_dark", 32'(total), 32'd0);
    cycle(1'b0, 1'b1, 1'b1, 8'h01);
    clear_hi();
    run_until_frame(2 * LMAX, n);
    total = 0;
    for (int i = 0; i < N; i++) total += hi[i];
    chk("arst_wait", 32'(total), 32'd0);
    measure();
    chk("arst_relit_ch0", 32'(hi[0]), 32'd15);

    // Randomized traffic against the model.
    for (int k = 0; k < 3000; k++) begin
      a = ($urandom_range(0, 199) == 0);
      e = ($urandom_range(0, 9) != 0);
      s = ($urandom_range(0, 5) == 0);
      if ($urandom_range(0, 3) == 0) l = N'($urandom);
      else                           l = N'(1 << $urandom_range(0, N - 1));
      cycle(a, e, s, l);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/knightrider_trail_pwm.md
Name: knightrider_trail_pwm

Overview:
- Downstream stage of top_knightrider. Consumes the one-hot leds[7:0] scanner pattern and drives the physical LED pins with PWM brightness.
- Each LED lit by the scanner jumps to full brightness. Unlit LEDs decay by a fixed amount per scanner step, which produces an afterglow trail behind the moving dot.
- Brightness changes are applied only at PWM period boundaries, so no period is ever glitched.

Parameters:
- N_LEDS, 8, number of LED channels; width of leds_in and pwm_o.
- PWM_BITS, 4, brightness resolution. LVL_MAX = 2**PWM_BITS-1 (15 by default).
- DECAY_STEP, 4, amount subtracted from an unlit channel's level on each accepted step. Legal range 1..LVL_MAX.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- arst  in  1  reset, synchronous, active-high.
- en  in  1  block enable, level-sensitive.
- step  in  1  single-cycle pulse, asserted when the scanner advances; sampled together with leds_in.
- leds_in  in  N_LEDS  scanner pattern (normally one-hot), valid when step=1.
- pwm_o  out  N_LEDS  PWM drive to the LED pins, registered.
- frame_o  out  1  one-cycle pulse marking the start of a PWM period in which new levels are active, registered.

Behaviour:
- Reset (arst=1 at a rising edge) has priority over everything else. It sets pwm_cnt=0, shadow_lvl[*]=0, act_lvl[*]=0, pwm_o=0 and frame_o=0. Reset mid-period aborts the period immediately; there is no partial-state retention.
- pwm_cnt is a PWM_BITS-wide counter running 0..LVL_MAX-1, so one period is LVL_MAX cycles.
  - It increments on every en=1 cycle.
  - At LVL_MAX-1 it wraps to 0; this wrap edge is the "period end".
- Shadow update, on an edge with en=1 and step=1, for each channel i:
  - leds_in[i]=1: shadow_lvl[i] <= LVL_MAX.
  - leds_in[i]=0: shadow_lvl[i] <= shadow_lvl[i] - DECAY_STEP, saturating at 0 with no underflow wrap.
  - Multiple set bits in leds_in are legal; each set bit loads LVL_MAX independently.
- Active load: at the period-end edge (en=1, pwm_cnt==LVL_MAX-1), act_lvl <= shadow_lvl.
  - The same edge sets frame_o <= 1. frame_o is 0 on every other edge.
  - If step and period end coincide, act_lvl takes the pre-update shadow value. The new shadow value becomes active at the following period end.
- Output: pwm_o[i] <= en & (pwm_cnt < act_lvl[i]), registered, one cycle after the pwm_cnt value it reflects.
  - act_lvl=LVL_MAX gives a constantly-high output.
  - act_lvl=0 gives a constantly-low output.
  - A level L gives exactly L high cycles per period.
- Latency: a step accepted at edge t reaches pwm_o no earlier than the first period end after t, plus one cycle.
- en=0 behaviour:
  - pwm_cnt, shadow_lvl and act_lvl hold.
  - step is ignored.
  - pwm_o is 0 and frame_o is 0 from the next edge.
  - On re-enable, counting resumes from the held pwm_cnt.
- No state depends on leds_in when step=0.

Test Plan (defaults: N_LEDS=8, PWM_BITS=4, DECAY_STEP=4):
- Reset: arst=1 for 2 cycles with random step/leds_in → pwm_o=0x00, frame_o=0; after release and 30 en cycles with no step, pwm_o stays 0x00 and frame_o pulses exactly every 15 cycles.
- Single step with leds_in=0x01 → after the next frame_o pulse, pwm_o[0] is high for all 15 cycles of every period and pwm_o[7:1]=0.
- Trail: steps with leds_in 0x01, 0x02, 0x04, 0x08, one per period → act_lvl for channels 0..3 becomes 3, 7, 11, 15; pwm_o[0] high 3 of 15 cycles and pwm_o[3] high 15 of 15. A further step with 0x10 gives channel 0 level 0 (saturation, no wrap to 15).
- Coincident step and period end with leds_in=0x80 → the period that starts then still uses the old levels (pwm_o[7]=0); the next period shows pwm_o[7] high for 15 cycles.
- en=0 mid-period for 10 cycles, with step pulses during it → pwm_o=0 and no frame_o during that time; levels unchanged; after en=1 the period completes the remaining count (frame spacing = 15 enabled cycles) with the prior duty.
- arst pulse mid-period while channel levels are nonzero → all outputs 0 on the next edge; after release, no output until a new step is followed by a period end.
